// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the instruction encoder:
//   - 4-bit mnemonic codes accepted on mnem_i
//   - 6-bit MIPS opcode constants matching the main control decoder
//   - encoder FSM state type
//   - helper that packs an I-type word
// Optional feature macro: INSTR_ENC_EXT_BRANCH_EN (bge/bgt become legal).
// -----------------------------------------------------------------------------
package instr_enc_pkg;

   // Mnemonic codes (9-15 are always illegal)
   localparam logic [3:0] MN_R    = 4'd0;
   localparam logic [3:0] MN_BEQ  = 4'd1;
   localparam logic [3:0] MN_BNE  = 4'd2;
   localparam logic [3:0] MN_BGE  = 4'd3;
   localparam logic [3:0] MN_BGT  = 4'd4;
   localparam logic [3:0] MN_ADDI = 4'd5;
   localparam logic [3:0] MN_SLTI = 4'd6;
   localparam logic [3:0] MN_LW   = 4'd7;
   localparam logic [3:0] MN_SW   = 4'd8;

   // Opcodes as consumed by the control decoder
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGE  = 6'b000001;
   localparam logic [5:0] OP_BGT  = 6'b000111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } enc_state_t;

   function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                              input logic [4:0]  rs,
                                              input logic [4:0]  rt,
                                              input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_word_pack.sv
// -----------------------------------------------------------------------------
// instr_word_pack
// Combinational packer: mnemonic plus instruction fields -> 32-bit MIPS word
// and a legal flag. Illegal mnemonics produce word 0 with o_legal=0.
// Optional feature macro: INSTR_ENC_EXT_BRANCH_EN (bge/bgt legal when defined).
// Ports:
//   i_mnem   [3:0]  mnemonic code
//   i_rs/i_rt/i_rd/i_shamt [4:0], i_funct [5:0], i_imm [15:0]  fields
//   o_word   [31:0] packed instruction
//   o_legal         mnemonic is encodable in this build
// -----------------------------------------------------------------------------
module instr_word_pack
   import instr_enc_pkg::*;
(
   input  logic [3:0]  i_mnem,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [5:0]  i_funct,
   input  logic [15:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b0;
      case (i_mnem)
         MN_R: begin
            o_word  = {OP_R, i_rs, i_rt, i_rd, i_shamt, i_funct};
            o_legal = 1'b1;
         end
         MN_BEQ: begin
            o_word  = pack_itype(OP_BEQ, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         MN_BNE: begin
            o_word  = pack_itype(OP_BNE, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
`ifdef INSTR_ENC_EXT_BRANCH_EN
         MN_BGE: begin
            o_word  = pack_itype(OP_BGE, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         MN_BGT: begin
            o_word  = pack_itype(OP_BGT, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
`endif
         MN_ADDI: begin
            o_word  = pack_itype(OP_ADDI, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         MN_SLTI: begin
            o_word  = pack_itype(OP_SLTI, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         MN_LW: begin
            o_word  = pack_itype(OP_LW, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         MN_SW: begin
            o_word  = pack_itype(OP_SW, i_rs, i_rt, i_imm);
            o_legal = 1'b1;
         end
         default: begin
            o_word  = '0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts symbolic instruction requests over valid/ready, packs them into
// 32-bit MIPS words and writes them sequentially into instruction memory over
// a write/ack port. A load session starts at start_addr_i (word aligned) and
// stops in FULL after WORD_LIMIT words until load_addr_i restarts it.
// Optional feature macro: INSTR_ENC_EXT_BRANCH_EN (bge/bgt legal when defined).
// Parameters: ADDR_W (byte address width, wraps), WORD_LIMIT (words/session).
// Ports:
//   clk_i, rst_i (async, active low)
//   req_valid_i / req_ready_o           request handshake
//   mnem_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i   request fields
//   load_addr_i, start_addr_i           session restart
//   imem_we_o, imem_addr_o, imem_data_o, imem_ack_i     memory write port
//   err_o (sticky illegal mnemonic), full_o, count_o (words this session)
// -----------------------------------------------------------------------------
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned WORD_LIMIT = 256
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        mnem_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        shamt_i,
   input  logic [5:0]        funct_i,
   input  logic [15:0]       imm_i,
   input  logic              load_addr_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   input  logic              imem_ack_i,
   output logic              err_o,
   output logic              full_o,
   output logic [8:0]        count_o
);

   localparam logic [8:0] LIMIT = 9'(WORD_LIMIT);

   enc_state_t        r_state;
   enc_state_t        w_state_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_err;
   logic [8:0]        r_count;

   logic [31:0]       w_word;
   logic              w_legal;
   logic              w_handshake;
   logic              w_ack;
   logic              w_reload;
   logic [8:0]        w_count_inc;

   instr_word_pack u_pack (
      .i_mnem  (mnem_i),
      .i_rs    (rs_i),
      .i_rt    (rt_i),
      .i_rd    (rd_i),
      .i_shamt (shamt_i),
      .i_funct (funct_i),
      .i_imm   (imm_i),
      .o_word  (w_word),
      .o_legal (w_legal)
   );

   assign req_ready_o = (r_state == ST_IDLE) && !load_addr_i;
   assign w_handshake = req_valid_i && req_ready_o;
   // ack only counts while a write is actually outstanding
   assign w_ack       = r_we && imem_ack_i;
   // load_addr_i is ignored while a write is in flight
   assign w_reload    = load_addr_i && (r_state != ST_WRITE);
   assign w_count_inc = r_count + 9'd1;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_handshake && w_legal) w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (w_ack) w_state_next = (w_count_inc == LIMIT) ? ST_FULL : ST_IDLE;
         end
         ST_FULL: begin
            if (load_addr_i) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else if (w_reload) begin
         r_addr  <= {start_addr_i[ADDR_W-1:2], 2'b00};
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (w_handshake) begin
         if (w_legal) begin
            r_data <= w_word;
            r_we   <= 1'b1;
         end else begin
            r_err  <= 1'b1;
         end
      end else if (r_state == ST_WRITE && w_ack) begin
         r_we    <= 1'b0;
         r_addr  <= r_addr + ADDR_W'(4);
         r_count <= w_count_inc;
      end
   end

   assign imem_we_o   = r_we;
   assign imem_addr_o = r_addr;
   assign imem_data_o = r_data;
   assign err_o       = r_err;
   assign full_o      = (r_state == ST_FULL);
   assign count_o     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Scoreboard bench for instr_encoder (WORD_LIMIT overridden to 4). Expected
// writes are queued when a request is accepted and checked by the memory
// responder when the DUT raises imem_we_o.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int unsigned ADDR_W = 10;

   logic              clk_i;
   logic              rst_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [3:0]        mnem_i;
   logic [4:0]        rs_i, rt_i, rd_i, shamt_i;
   logic [5:0]        funct_i;
   logic [15:0]       imm_i;
   logic              load_addr_i;
   logic [ADDR_W-1:0] start_addr_i;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_data_o;
   logic              imem_ack_i;
   logic              err_o;
   logic              full_o;
   logic [8:0]        count_o;

   instr_encoder #(.ADDR_W(ADDR_W), .WORD_LIMIT(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .mnem_i       (mnem_i),
      .rs_i         (rs_i),
      .rt_i         (rt_i),
      .rd_i         (rd_i),
      .shamt_i      (shamt_i),
      .funct_i      (funct_i),
      .imm_i        (imm_i),
      .load_addr_i  (load_addr_i),
      .start_addr_i (start_addr_i),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_data_o  (imem_data_o),
      .imem_ack_i   (imem_ack_i),
      .err_o        (err_o),
      .full_o       (full_o),
      .count_o      (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int unsigned       delay;
   } exp_t;

   exp_t              sb[$];
   int                checks = 0;
   int                errors = 0;
   int                writes = 0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [8:0]        exp_count = '0;

   // Memory responder: acks after the queued delay, checks data and holding
   logic              in_wr = 1'b0;
   int unsigned       waitc = 0;
   logic [ADDR_W-1:0] hold_addr;
   logic [31:0]       hold_data;

   initial begin
      imem_ack_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            imem_ack_i = 1'b0;
            in_wr = 1'b0;
            waitc = 0;
         end else if (imem_we_o) begin
            if (!in_wr) begin
               in_wr = 1'b1;
               waitc = 0;
               hold_addr = imem_addr_o;
               hold_data = imem_data_o;
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr_o, imem_data_o);
               end
            end else begin
               checks++;
               if (imem_addr_o !== hold_addr || imem_data_o !== hold_data) begin
                  errors++;
                  $display("FAIL write_hold: addr=%h data=%h, required addr=%h data=%h", imem_addr_o, imem_data_o, hold_addr, hold_data);
               end
            end
            checks++;
            if (req_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL ready_during_write: ready=%b, required 0", req_ready_o);
            end
            if (sb.size() == 0) begin
               imem_ack_i = 1'b1;
            end else if (waitc == sb[0].delay) begin
               checks++;
               if (imem_addr_o !== sb[0].addr || imem_data_o !== sb[0].data) begin
                  errors++;
                  $display("FAIL write_content: addr=%h data=%h, required addr=%h data=%h", imem_addr_o, imem_data_o, sb[0].addr, sb[0].data);
               end
               void'(sb.pop_front());
               writes++;
               imem_ack_i = 1'b1;
            end else begin
               imem_ack_i = 1'b0;
               waitc++;
            end
         end else begin
            imem_ack_i = 1'b0;
            in_wr = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic load_pulse(input logic [ADDR_W-1:0] a);
      @(posedge clk_i); #1;
      load_addr_i  = 1'b1;
      start_addr_i = a;
      @(posedge clk_i); #1;
      load_addr_i  = 1'b0;
      exp_addr  = {a[ADDR_W-1:2], 2'b00};
      exp_count = '0;
      checks++;
      if (count_o !== 9'd0 || err_o !== 1'b0 || imem_addr_o !== exp_addr) begin
         errors++;
         $display("FAIL load_addr: count=%0d err=%b addr=%h, required 0 0 %h", count_o, err_o, imem_addr_o, exp_addr);
      end
   endtask

   // Drives one request; returns just after the accepting edge (#1)
   task automatic send_req(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] imm, input bit legal, input logic [31:0] word,
                           input int unsigned dly);
      bit got;
      got = 1'b0;
      mnem_i = m; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh; funct_i = fn; imm_i = imm;
      req_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL req_accept_timeout: ready=%b, required 1 within 100 cycles", req_ready_o);
      end else if (legal) begin
         sb.push_back('{addr: exp_addr, data: word, delay: dly});
         exp_addr  = exp_addr + ADDR_W'(4);
         exp_count = exp_count + 9'd1;
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (sb.size() == 0 && !imem_we_o) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d we=%b, required 0 0", sb.size(), imem_we_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      checks++;
      if (imem_we_o !== 1'b0 || imem_addr_o !== '0 || imem_data_o !== '0 ||
          err_o !== 1'b0 || full_o !== 1'b0 || count_o !== 9'd0) begin
         errors++;
         $display("FAIL reset_values: we=%b addr=%h data=%h err=%b full=%b count=%0d, required all 0",
                  imem_we_o, imem_addr_o, imem_data_o, err_o, full_o, count_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: ready=%b, required 1", req_ready_o);
      end
   endtask

   task automatic test_rtype();
      load_pulse(10'h040);
      send_req(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b1, 32'h00221820, 0);
      @(negedge clk_i);
      checks++;
      if (imem_we_o !== 1'b1 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rtype_latency1: we=%b ready=%b, required 1 0", imem_we_o, req_ready_o);
      end
      @(negedge clk_i);
      checks++;
      if (imem_we_o !== 1'b0 || req_ready_o !== 1'b1 || count_o !== 9'd1 || imem_addr_o !== 10'h044) begin
         errors++;
         $display("FAIL rtype_latency2: we=%b ready=%b count=%0d addr=%h, required 0 1 1 044",
                  imem_we_o, req_ready_o, count_o, imem_addr_o);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      load_pulse(10'h043);
      send_req(4'd5, 5'd0,  5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1, 32'h20080005, 0);
      send_req(4'd7, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b1, 32'h8FA80004, 3);
      send_req(4'd8, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b1, 32'hAFA80008, 0);
      wait_idle();
      checks++;
      if (count_o !== exp_count || imem_addr_o !== 10'h04C || writes != 4) begin
         errors++;
         $display("FAIL back_to_back: count=%0d addr=%h writes=%0d, required %0d 04c 4",
                  count_o, imem_addr_o, writes, exp_count);
      end
   endtask

   task automatic test_illegal();
      int w0;
      load_pulse(10'h100);
      send_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1, 32'h1022FFFF, 1);
      wait_idle();
      w0 = writes;
      send_req(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b0, 32'h0, 0);
      repeat (3) begin
         @(negedge clk_i);
         checks++;
         if (imem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_no_we: we=%b, required 0", imem_we_o);
         end
      end
      checks++;
      if (err_o !== 1'b1 || count_o !== 9'd1 || req_ready_o !== 1'b1 || writes != w0) begin
         errors++;
         $display("FAIL illegal_flag: err=%b count=%0d ready=%b writes=%0d, required 1 1 1 %0d",
                  err_o, count_o, req_ready_o, writes, w0);
      end
      load_pulse(10'h100);
   endtask

   task automatic test_ext_branch();
      bit legal;
`ifdef INSTR_ENC_EXT_BRANCH_EN
      legal = 1'b1;
`else
      legal = 1'b0;
`endif
      load_pulse(10'h200);
      send_req(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, legal, 32'h04220003, 0);
      wait_idle();
      repeat (2) @(negedge clk_i);
      checks++;
      if (err_o !== !legal || count_o !== (legal ? 9'd1 : 9'd0)) begin
         errors++;
         $display("FAIL ext_branch: err=%b count=%0d, required %b %0d", err_o, count_o, !legal, legal ? 1 : 0);
      end
   endtask

   task automatic test_full();
      load_pulse(10'h3F8);
      for (int i = 0; i < 4; i++) begin
         logic [15:0] imm;
         imm = 16'(i + 1);
         send_req(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, imm, 1'b1, 32'h20080000 | 32'(imm), i % 2);
      end
      wait_idle();
      checks++;
      if (full_o !== 1'b1 || req_ready_o !== 1'b0 || count_o !== 9'd4 || imem_addr_o !== 10'h008) begin
         errors++;
         $display("FAIL full_state: full=%b ready=%b count=%0d addr=%h, required 1 0 4 008",
                  full_o, req_ready_o, count_o, imem_addr_o);
      end
      @(posedge clk_i); #1;
      mnem_i = 4'd5; imm_i = 16'h00AA;
      req_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== 1'b0 || full_o !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: ready=%b full=%b, required 0 1", req_ready_o, full_o);
         end
      end
      @(posedge clk_i); #1;
      load_addr_i  = 1'b1;
      start_addr_i = 10'h080;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL load_priority_ready: ready=%b, required 0", req_ready_o);
      end
      @(posedge clk_i); #1;
      load_addr_i = 1'b0;
      req_valid_i = 1'b0;
      exp_addr  = 10'h080;
      exp_count = '0;
      @(negedge clk_i);
      checks++;
      if (count_o !== 9'd0 || full_o !== 1'b0 || req_ready_o !== 1'b1 ||
          imem_we_o !== 1'b0 || imem_addr_o !== 10'h080) begin
         errors++;
         $display("FAIL load_priority: count=%0d full=%b ready=%b we=%b addr=%h, required 0 0 1 0 080",
                  count_o, full_o, req_ready_o, imem_we_o, imem_addr_o);
      end
   endtask

   task automatic test_reset_mid_write();
      load_pulse(10'h000);
      send_req(4'd6, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b1, 32'h28850010, 10);
      @(negedge clk_i);
      checks++;
      if (imem_we_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_write_we: we=%b, required 1", imem_we_o);
      end
      #2 rst_i = 1'b0;
      #1;
      checks++;
      if (imem_we_o !== 1'b0 || imem_addr_o !== '0 || imem_data_o !== '0 ||
          err_o !== 1'b0 || full_o !== 1'b0 || count_o !== 9'd0) begin
         errors++;
         $display("FAIL reset_mid_write: we=%b addr=%h data=%h err=%b full=%b count=%0d, required all 0",
                  imem_we_o, imem_addr_o, imem_data_o, err_o, full_o, count_o);
      end
      sb.delete();
      repeat (2) @(posedge clk_i);
      #2 rst_i = 1'b1;
      exp_addr  = '0;
      exp_count = '0;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1 || imem_we_o !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: ready=%b we=%b, required 1 0", req_ready_o, imem_we_o);
      end
   endtask

   initial begin
      rst_i = 1'b0;
      req_valid_i = 1'b0;
      mnem_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0; funct_i = '0; imm_i = '0;
      load_addr_i = 1'b0;
      start_addr_i = '0;
      test_reset();
      test_rtype();
      test_back_to_back();
      test_illegal();
      test_ext_branch();
      test_full();
      test_reset_mid_write();
      repeat (3) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
